// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_top transmitter among N_REQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               cfg_parity_sel,
  input  logic               cfg_stop_sel,
  input  logic [11:0]        cfg_baud_divisor,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               valid_in,
  output logic [7:0]         data_in,
  output logic               parity_sel,
  output logic               stop_sel,
  output logic [11:0]        baud_divisor
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FRAME,
    ST_GAP
  } state_t;

  state_t state, state_next;

  logic [7:0]       req_pad;
  logic [63:0]      data_pad;
  logic [2:0]       winner;
  logic             found;

  logic [3:0]       frame_bits;
  logic [11:0]      bit_cycles;
  logic             bit_last;
  logic             frame_last;
  logic             gap_last;

  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [11:0]      cyc_cnt, cyc_cnt_next;
  logic [3:0]       gap_cnt, gap_cnt_next;

  logic [N_REQ-1:0] gnt_next;
  logic [2:0]       owner_next;
  logic             busy_next;
  logic             valid_next;
  logic [7:0]       data_next;
  logic             parity_next;
  logic             stop_next;
  logic [11:0]      baud_next;

  // Pad to the 8-requester maximum so every select uses an exact-width index.
  assign req_pad  = 8'(req);
  assign data_pad = 64'(req_data);

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req_pad[3'(i)]) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
  end
`else
  logic [2:0] rr, rr_next;
  logic [3:0] idx;

  // Cyclic search starting at rr; the first set request wins.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    idx    = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr} + 4'(i);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      if (!found && req_pad[idx[2:0]]) begin
        winner = idx[2:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rr_next = rr;
    if (state == ST_IDLE && found)
      rr_next = (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr <= 3'd0;
    else        rr <= rr_next;
  end
`endif

  // Frame timing derives from the latched configuration, never from cfg_* directly.
  assign frame_bits = 4'd10 + {3'b000, parity_sel} + {3'b000, stop_sel};
  assign bit_cycles = (baud_divisor == 12'd0) ? 12'd1 : baud_divisor;
  assign bit_last   = (cyc_cnt == bit_cycles - 12'd1);
  assign frame_last = bit_last && (bit_cnt == frame_bits - 4'd1);
  assign gap_last   = (gap_cnt == 4'(GAP - 1));

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    cyc_cnt_next = cyc_cnt;
    gap_cnt_next = gap_cnt;
    gnt_next     = '0;
    valid_next   = 1'b0;
    owner_next   = owner;
    data_next    = data_in;
    parity_next  = parity_sel;
    stop_next    = stop_sel;
    baud_next    = baud_divisor;

    case (state)
      ST_IDLE: begin
        if (found) begin
          state_next  = ST_LOAD;
          valid_next  = 1'b1;
          owner_next  = winner;
          data_next   = data_pad[{winner, 3'b000} +: 8];
          parity_next = cfg_parity_sel;
          stop_next   = cfg_stop_sel;
          baud_next   = cfg_baud_divisor;
          for (int i = 0; i < N_REQ; i++) gnt_next[i] = (winner == 3'(i));
        end
      end
      ST_LOAD: begin
        state_next   = ST_FRAME;
        bit_cnt_next = 4'd0;
        cyc_cnt_next = 12'd0;
      end
      ST_FRAME: begin
        if (bit_last) begin
          cyc_cnt_next = 12'd0;
          if (frame_last) begin
            state_next   = (GAP == 0) ? ST_IDLE : ST_GAP;
            gap_cnt_next = 4'd0;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end else begin
          cyc_cnt_next = cyc_cnt + 12'd1;
        end
      end
      ST_GAP: begin
        if (gap_last) state_next = ST_IDLE;
        else          gap_cnt_next = gap_cnt + 4'd1;
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 4'd0;
      cyc_cnt      <= 12'd0;
      gap_cnt      <= 4'd0;
      gnt          <= '0;
      owner        <= 3'd0;
      busy         <= 1'b0;
      valid_in     <= 1'b0;
      data_in      <= 8'd0;
      parity_sel   <= 1'b0;
      stop_sel     <= 1'b0;
      baud_divisor <= 12'd0;
    end else begin
      state        <= state_next;
      bit_cnt      <= bit_cnt_next;
      cyc_cnt      <= cyc_cnt_next;
      gap_cnt      <= gap_cnt_next;
      gnt          <= gnt_next;
      owner        <= owner_next;
      busy         <= busy_next;
      valid_in     <= valid_next;
      data_in      <= data_next;
      parity_sel   <= parity_next;
      stop_sel     <= stop_next;
      baud_divisor <= baud_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, GAP=2).
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int GAP   = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [N_REQ-1:0]   req = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic               cfg_parity_sel = 1'b0;
  logic               cfg_stop_sel = 1'b0;
  logic [11:0]        cfg_baud_divisor = 12'd0;
  logic [N_REQ-1:0]   gnt;
  logic [2:0]         owner;
  logic               busy;
  logic               valid_in;
  logic [7:0]         data_in;
  logic               parity_sel;
  logic               stop_sel;
  logic [11:0]        baud_divisor;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N_REQ), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .cfg_parity_sel(cfg_parity_sel), .cfg_stop_sel(cfg_stop_sel),
    .cfg_baud_divisor(cfg_baud_divisor), .gnt(gnt), .owner(owner), .busy(busy),
    .valid_in(valid_in), .data_in(data_in), .parity_sel(parity_sel),
    .stop_sel(stop_sel), .baud_divisor(baud_divisor)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    req_data = '0;
    cfg_parity_sel = 1'b0;
    cfg_stop_sel = 1'b0;
    cfg_baud_divisor = 12'd0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int cnt;
    req = 4'hF;
    req_data = 32'h4433_2211;
    cfg_parity_sel = 1'b1;
    cfg_stop_sel = 1'b1;
    cfg_baud_divisor = 12'd7;
    reset = 1'b0;
    step();
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    checks++; if (owner !== 3'd0) begin errors++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (valid_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_in); end
    checks++; if (data_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data_in); end
    checks++; if (parity_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity: got %b expected 0", parity_sel); end
    checks++; if (stop_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_stop: got %b expected 0", stop_sel); end
    checks++; if (baud_divisor !== 12'd0) begin errors++; $display("[TB] FAIL reset_baud: got %0d expected 0", baud_divisor); end
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt++;
      if (valid_in === 1'b1) break;
    end
    checks++; if (valid_in !== 1'b1 || cnt > 2) begin errors++; $display("[TB] FAIL release_latency: got %0d cycles (valid=%b) expected <=2", cnt, valid_in); end
    checks++; if (owner !== 3'd0) begin errors++; $display("[TB] FAIL release_owner: got %0d expected 0", owner); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL release_gnt: got %b expected 0001", gnt); end
    checks++; if (data_in !== 8'h11) begin errors++; $display("[TB] FAIL release_data: got %h expected 11", data_in); end
    do_reset();
  endtask

  task automatic test_single();
    int cnt;
    int extra;
    do_reset();
    req = 4'b0010;
    req_data = 32'h0000_3900;
    cfg_baud_divisor = 12'd3;
    step();
    checks++; if (valid_in !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", valid_in); end
    checks++; if (data_in !== 8'h39) begin errors++; $display("[TB] FAIL single_data: got %h expected 39", data_in); end
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL single_gnt: got %b expected 0010", gnt); end
    checks++; if (owner !== 3'd1) begin errors++; $display("[TB] FAIL single_owner: got %0d expected 1", owner); end
    checks++; if (baud_divisor !== 12'd3) begin errors++; $display("[TB] FAIL single_baud: got %0d expected 3", baud_divisor); end
    req = '0;
    cnt = (busy === 1'b1) ? 1 : 0;
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy !== 1'b1) break;
      cnt++;
      if (valid_in === 1'b1 || gnt !== 4'b0000) extra++;
    end
    checks++; if (cnt != 33) begin errors++; $display("[TB] FAIL single_busy_len: got %0d expected 33", cnt); end
    checks++; if (extra != 0) begin errors++; $display("[TB] FAIL single_extra_strobe: got %0d expected 0", extra); end
    step();
    checks++; if (valid_in !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got valid=%b busy=%b expected 0 0", valid_in, busy); end
  endtask

  task automatic test_round_robin();
    int n;
    int cyc;
    int exp_owner[4];
    int got_owner[4];
    logic [3:0] got_gnt[4];
    logic [7:0] got_data[4];
    int got_cyc[4];
    logic [7:0] exp_data;
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_owner = '{0, 0, 0, 0};
`else
    exp_owner = '{0, 2, 0, 2};
`endif
    do_reset();
    req = 4'b0101;
    req_data = 32'h00C3_00A1;
    cfg_baud_divisor = 12'd1;
    n = 0;
    cyc = 0;
    for (int i = 0; i < 120 && n < 4; i++) begin
      step();
      cyc++;
      if (valid_in === 1'b1) begin
        got_owner[n] = int'(owner);
        got_gnt[n] = gnt;
        got_data[n] = data_in;
        got_cyc[n] = cyc;
        n++;
      end
    end
    req = '0;
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL rr_count: got %0d strobes expected 4", n); end
    for (int k = 0; k < n; k++) begin
      exp_data = (exp_owner[k] == 2) ? 8'hC3 : 8'hA1;
      checks++; if (got_owner[k] != exp_owner[k]) begin errors++; $display("[TB] FAIL rr_owner%0d: got %0d expected %0d", k, got_owner[k], exp_owner[k]); end
      checks++; if (got_gnt[k] !== 4'(1 << exp_owner[k])) begin errors++; $display("[TB] FAIL rr_gnt%0d: got %b expected %b", k, got_gnt[k], 4'(1 << exp_owner[k])); end
      checks++; if (got_data[k] !== exp_data) begin errors++; $display("[TB] FAIL rr_data%0d: got %h expected %h", k, got_data[k], exp_data); end
      if (k > 0) begin
        checks++; if (got_cyc[k] - got_cyc[k-1] != 14) begin errors++; $display("[TB] FAIL rr_spacing%0d: got %0d expected 14", k, got_cyc[k] - got_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_cfg_latch();
    int cnt;
    do_reset();
    req = 4'b0001;
    req_data = 32'h0000_00A5;
    cfg_parity_sel = 1'b1;
    cfg_stop_sel = 1'b1;
    cfg_baud_divisor = 12'd2;
    step();
    checks++; if (valid_in !== 1'b1) begin errors++; $display("[TB] FAIL latch_valid: got %b expected 1", valid_in); end
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cnt++;
      if (cnt == 3) begin
        cfg_parity_sel = 1'b0;
        cfg_stop_sel = 1'b0;
        cfg_baud_divisor = 12'd5;
      end
      if (cnt == 12) begin
        checks++; if ({parity_sel, stop_sel, baud_divisor} !== {1'b1, 1'b1, 12'd2}) begin errors++; $display("[TB] FAIL latch_hold: got %b/%b/%0d expected 1/1/2", parity_sel, stop_sel, baud_divisor); end
      end
      if (valid_in === 1'b1) break;
    end
    checks++; if (cnt != 28) begin errors++; $display("[TB] FAIL latch_spacing1: got %0d expected 28", cnt); end
    checks++; if ({parity_sel, stop_sel, baud_divisor} !== {1'b0, 1'b0, 12'd5}) begin errors++; $display("[TB] FAIL latch_next_cfg: got %b/%b/%0d expected 0/0/5", parity_sel, stop_sel, baud_divisor); end
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      cnt++;
      if (valid_in === 1'b1) break;
    end
    req = '0;
    checks++; if (cnt != 54) begin errors++; $display("[TB] FAIL latch_spacing2: got %0d expected 54", cnt); end
  endtask

  task automatic test_div0();
    int cnt;
    do_reset();
    req = 4'b0100;
    req_data = 32'h005A_0000;
    cfg_baud_divisor = 12'd0;
    step();
    checks++; if (valid_in !== 1'b1 || data_in !== 8'h5A) begin errors++; $display("[TB] FAIL div0_strobe: got valid=%b data=%h expected 1 5a", valid_in, data_in); end
    checks++; if (baud_divisor !== 12'd0) begin errors++; $display("[TB] FAIL div0_baud: got %0d expected 0", baud_divisor); end
    req = '0;
    cnt = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (busy !== 1'b1) break;
      cnt++;
    end
    checks++; if (cnt != 13) begin errors++; $display("[TB] FAIL div0_busy_len: got %0d expected 13", cnt); end
  endtask

  task automatic test_midframe_reset();
    int bad;
    do_reset();
    req = 4'b0100;
    req_data = 32'h0077_0000;
    cfg_baud_divisor = 12'd4;
    step();
    checks++; if (owner !== 3'd2) begin errors++; $display("[TB] FAIL mid_owner: got %0d expected 2", owner); end
    req = '0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy_after: got %b expected 0", busy); end
    checks++; if (owner !== 3'd0 || data_in !== 8'h00 || baud_divisor !== 12'd0) begin errors++; $display("[TB] FAIL mid_regs_after: got owner=%0d data=%h baud=%0d expected 0 00 0", owner, data_in, baud_divisor); end
    step();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy !== 1'b0 || valid_in !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL mid_stays_idle: got %0d active cycles expected 0", bad); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting uart_tx_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_cfg_latch();
    test_div0();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_top` transmitter among `N_REQ` byte producers. It picks a winner, issues a single-cycle `valid_in` with the winner's byte and a latched frame configuration, then holds off new transfers for the full frame time it computes from that configuration, plus a fixed inter-frame gap. It sits directly in front of `uart_top`, and its outputs drive that block's `valid_in`, `data_in`, `parity_sel`, `stop_sel` and `baud_divisor` inputs.

## Interface
- `N_REQ`, 4: number of requesters, from 2 to 8.
- `GAP`, 2: idle cycles inserted after each frame, from 0 to 15.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, N_REQ: per-requester transfer request.
- `req_data`, in, 8*N_REQ: byte for requester i, at bits [8i+7:8i].
- `cfg_parity_sel`, in, 1: parity enable for the next frame.
- `cfg_stop_sel`, in, 1: 0 selects one stop bit, 1 selects two.
- `cfg_baud_divisor`, in, 12: clock cycles per bit.
- `gnt`, out, N_REQ: one-hot, one-cycle acknowledge.
- `owner`, out, 3: index of the current or last winner.
- `busy`, out, 1: a transfer is in progress.
- `valid_in`, out, 1: strobe to `uart_top`.
- `data_in`, out, 8: byte to `uart_top`.
- `parity_sel`, out, 1: to `uart_top`.
- `stop_sel`, out, 1: to `uart_top`.
- `baud_divisor`, out, 12: to `uart_top`.

## Operation
- FSM states:
  - IDLE → LOAD when `req` is nonzero.
  - LOAD → FRAME unconditionally.
  - FRAME → GAP, or → IDLE if `GAP`=0, when the frame count ends.
  - GAP → IDLE after `GAP` cycles.
- Arbitration happens in IDLE. The winner is the first set `req` bit at or after pointer `rr`, searched cyclically. In the same cycle the block captures the winner's byte, `cfg_parity_sel`, `cfg_stop_sel` and `cfg_baud_divisor` into registers.
- In LOAD the block drives:
  - `valid_in`=1;
  - `gnt[winner]`=1;
  - `data_in`, `parity_sel`, `stop_sel`, `baud_divisor` from the captured registers;
  - `rr` updated to winner+1, wrapping from N_REQ-1 to 0.
- `parity_sel`, `stop_sel`, `baud_divisor` and `data_in` hold their captured values until the next LOAD. Changes on `cfg_*` during a frame have no effect until the next capture.
- Frame length:
  - frame_bits = 10 + parity_sel + stop_sel, giving 10 to 12 bits.
  - bit_cycles = baud_divisor, with 0 treated as 1.
  - FRAME lasts frame_bits*bit_cycles cycles. It is counted with a 12-bit cycle counter nested in a 4-bit bit counter, so no wide multiply is needed.
- Requester contract:
  - Hold `req` and data until `gnt` is seen.
  - Drop `req` the cycle after `gnt`, or keep it high to queue another byte.
  - A request that drops before capture is simply not served. After capture, the state of `req` is ignored.
- `owner` updates in LOAD and holds its value afterwards.
- If `req`=0 in IDLE, the FSM stays in IDLE and all strobes stay 0.
- Reset may be asserted in any state. It aborts immediately and returns to IDLE with reset values. A frame already started inside `uart_top` is not tracked.

## Timing
- Reset values:
  - `gnt`=0, `owner`=0, `busy`=0, `valid_in`=0;
  - `data_in`=0, `parity_sel`=0, `stop_sel`=0, `baud_divisor`=0;
  - `rr`=0, state IDLE.
- A request seen in IDLE at cycle t produces `valid_in` and `gnt` at cycle t+1.
- `busy` is 1 from LOAD through the last GAP cycle, a total of 1 + frame_bits*bit_cycles + GAP cycles.
- The earliest next `valid_in` is 2 + frame_bits*bit_cycles + GAP cycles after the previous one.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. `rr` is not implemented.
  - Undefined: round-robin as described under Operation.

## Test plan
- Reset values:
  - Stimulus: assert `reset` low with `req`=4'hF.
  - Required: all outputs 0 and no `gnt`. After release, `valid_in` appears 2 cycles later and `owner`=0.
- Single transfer:
  - Stimulus: `req`=4'b0010, byte 8'h39, divisor 3, parity 0, stop 0.
  - Required: `valid_in` with `data_in`=8'h39 one cycle later, `gnt`=4'b0010, `busy` high for 1+30+2=33 cycles, then IDLE.
- Round-robin:
  - Stimulus: `req`=4'b0101 held continuously, divisor 1.
  - Required: grant order 0, 2, 0, 2, with consecutive `valid_in` strobes 14 cycles apart.
- Configuration latching:
  - Stimulus: parity 1, stop 1, divisor 2; change `cfg_*` to 0/0/5 during FRAME.
  - Required: outputs stay 1/1/2 and the frame lasts 24 cycles. The next frame uses 0/0/5.
- Divisor 0:
  - Stimulus: `cfg_baud_divisor`=0, parity 0, stop 0.
  - Required: FRAME lasts 10 cycles and `baud_divisor` output is 0.
- Mid-frame reset and macro:
  - Stimulus: reset during FRAME. Then, with `UART_ARB_FIXED_PRIO_EN` defined, hold `req`=4'b0101.
  - Required: after reset, immediate return to IDLE with `busy`=0. With the macro defined, every grant goes to requester 0.
